// File: rtl/sa_feeder.sv
// Feeds a 2x2 weight-stationary systolic array: clears accumulators, shifts in the job
// weights, then streams skewed activation vectors and drains the array before signalling done.
module sa_feeder #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] w11,
  input  logic [DATA_W-1:0] w12,
  input  logic [DATA_W-1:0] w21,
  input  logic [DATA_W-1:0] w22,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_a0,
  input  logic [DATA_W-1:0] act_a1,
  input  logic              act_last,
  output logic              clear,
  output logic              weight_load,
  output logic [DATA_W-1:0] w_in1,
  output logic [DATA_W-1:0] w_in2,
  output logic [DATA_W-1:0] act_in1,
  output logic [DATA_W-1:0] act_in2,
  output logic [DATA_W-1:0] psum_in1,
  output logic [DATA_W-1:0] psum_in2,
  output logic              busy,
  output logic              done,
  output logic [7:0]        vec_count
);

  typedef enum logic [2:0] {
    StIdle, StClear, StWload0, StWload1, StStream, StFlush, StDrain, StDone
  } state_e;

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [DATA_W-1:0] w11_q, w11_d, w12_q, w12_d, w21_q, w21_d, w22_q, w22_d;
  logic [7:0]        vec_count_q, vec_count_d;
  logic [DATA_W-1:0] skew_q, skew_d;
  logic [DATA_W-1:0] act_in1_q, act_in1_d, act_in2_q, act_in2_d;
  logic [DATA_W-1:0] w_in1_q, w_in1_d, w_in2_q, w_in2_d;
  logic              act_ready_q, act_ready_d, clear_q, clear_d, weight_load_q, weight_load_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept;

  // act_ready_q is high exactly while in StStream, so it doubles as the handshake qualifier.
  assign accept = act_ready_q & act_valid;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    w11_d       = w11_q;
    w12_d       = w12_q;
    w21_d       = w21_q;
    w22_d       = w22_q;
    vec_count_d = vec_count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w11_d       = w11;
          w12_d       = w12;
          w21_d       = w21;
          w22_d       = w22;
          vec_count_d = '0;
          state_d     = StClear;
        end
      end
      StClear:  state_d = StWload0;
      StWload0: state_d = StWload1;
      StWload1: state_d = StStream;
      StStream: begin
        if (accept) begin
          if (vec_count_q != 8'hFF) vec_count_d = vec_count_q + 8'd1;
          if (act_last) state_d = StFlush;
        end
      end
      StFlush: begin
        drain_cnt_d = '0;
        state_d     = (DRAIN_CYCLES == 0) ? StDone : StDrain;
      end
      StDrain: begin
        if (drain_cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    clear_d       = (state_d == StClear);
    weight_load_d = (state_d == StWload0) || (state_d == StWload1);
    act_ready_d   = (state_d == StStream);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
    w_in1_d       = '0;
    w_in2_d       = '0;
    if (state_d == StWload0) begin
      w_in1_d = w21_d;
      w_in2_d = w22_d;
    end else if (state_d == StWload1) begin
      w_in1_d = w11_d;
      w_in2_d = w12_d;
    end
    // Bubbles push zeros through both the row-1 path and the row-2 skew stage.
    act_in1_d = accept ? act_a0 : '0;
    skew_d    = accept ? act_a1 : '0;
    act_in2_d = skew_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      drain_cnt_q   <= '0;
      w11_q         <= '0;
      w12_q         <= '0;
      w21_q         <= '0;
      w22_q         <= '0;
      vec_count_q   <= '0;
      skew_q        <= '0;
      act_in1_q     <= '0;
      act_in2_q     <= '0;
      w_in1_q       <= '0;
      w_in2_q       <= '0;
      act_ready_q   <= 1'b0;
      clear_q       <= 1'b0;
      weight_load_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      w11_q         <= w11_d;
      w12_q         <= w12_d;
      w21_q         <= w21_d;
      w22_q         <= w22_d;
      vec_count_q   <= vec_count_d;
      skew_q        <= skew_d;
      act_in1_q     <= act_in1_d;
      act_in2_q     <= act_in2_d;
      w_in1_q       <= w_in1_d;
      w_in2_q       <= w_in2_d;
      act_ready_q   <= act_ready_d;
      clear_q       <= clear_d;
      weight_load_q <= weight_load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign act_ready   = act_ready_q;
  assign clear       = clear_q;
  assign weight_load = weight_load_q;
  assign w_in1       = w_in1_q;
  assign w_in2       = w_in2_q;
  assign act_in1     = act_in1_q;
  assign act_in2     = act_in2_q;
  assign psum_in1    = '0;
  assign psum_in2    = '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign vec_count   = vec_count_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: table of jobs run through a cycle-accurate driver with a queue
// scoreboard on the activation outputs, plus reset and saturation sequences.
module tb_sa_feeder;
  localparam int unsigned DW    = 8;
  localparam int unsigned DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, act_valid, act_last;
  logic [DW-1:0] w11, w12, w21, w22, act_a0, act_a1;
  logic          act_ready, clear, weight_load, busy, done;
  logic [DW-1:0] w_in1, w_in2, act_in1, act_in2, psum_in1, psum_in2;
  logic [7:0]    vec_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  typedef struct {
    logic [7:0]       w11, w12, w21, w22;
    int               nvec;
    logic [3:0][7:0]  a0;
    logic [3:0][7:0]  a1;
    logic [7:0]       pattern;   // bit c: act_valid in stream cycle c
    bit               start_mid;
    int               exp_count;
  } job_t;

  job_t jobs[5];

  sa_feeder #(.DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w11(w11), .w12(w12), .w21(w21), .w22(w22),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_a0(act_a0), .act_a1(act_a1), .act_last(act_last),
    .clear(clear), .weight_load(weight_load), .w_in1(w_in1), .w_in2(w_in2),
    .act_in1(act_in1), .act_in2(act_in2), .psum_in1(psum_in1), .psum_in2(psum_in2),
    .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; act_valid = 0; act_last = 0; act_a0 = 0; act_a1 = 0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e1, e2;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    check({tag, " act_in1"}, act_in1, e1);
    check({tag, " act_in2"}, act_in2, e2);
  endtask

  task automatic run_job(input job_t j, input int id);
    string      t;
    int         idx, c;
    logic       vld;
    logic [7:0] skew;
    t = $sformatf("job%0d", id);
    q1.delete(); q2.delete();
    w11 = j.w11; w12 = j.w12; w21 = j.w21; w22 = j.w22; start = 1;
    step();
    start = 0; w11 = 8'hA5; w12 = 8'hA5; w21 = 8'hA5; w22 = 8'hA5;
    check({t, " clear"}, clear, 1);
    check({t, " busy"}, busy, 1);
    check({t, " count zeroed"}, vec_count, 0);
    check({t, " wl in clear"}, weight_load, 0);
    step();
    check({t, " wl0"}, weight_load, 1);
    check({t, " clear off"}, clear, 0);
    check({t, " wload0 w_in"}, {w_in1, w_in2}, {j.w21, j.w22});
    step();
    check({t, " wl1"}, weight_load, 1);
    check({t, " wload1 w_in"}, {w_in1, w_in2}, {j.w11, j.w12});
    step();
    check({t, " stream wl"}, {weight_load, w_in1, w_in2}, 0);
    check({t, " first act_in"}, {act_in1, act_in2}, 0);
    idx = 0; skew = 0; c = 0;
    while (idx < j.nvec) begin
      vld = (c < 8) ? j.pattern[c[2:0]] : 1'b1;
      check({t, " ready"}, act_ready, 1);
      act_valid = vld;
      act_a0    = vld ? j.a0[idx] : 8'hEE;
      act_a1    = vld ? j.a1[idx] : 8'hEE;
      act_last  = vld ? (idx == j.nvec - 1) : 1'b1;
      if (j.start_mid && c == 0) begin
        start = 1; w11 = 8'h11; w12 = 8'h22; w21 = 8'h33; w22 = 8'h44;
      end
      q1.push_back(vld ? act_a0 : 8'h00);
      q2.push_back(skew);
      skew = vld ? act_a1 : 8'h00;
      step();
      idle_inputs();
      if (vld) idx++;
      c++;
      pop_check(t);
    end
    // flush
    check({t, " flush ready"}, act_ready, 0);
    check({t, " flush busy/done"}, {busy, done}, 2'b10);
    q1.push_back(0); q2.push_back(skew); skew = 0;
    step();
    pop_check({t, " flush"});
    for (int d = 0; d < DRAIN; d++) begin
      check({t, " drain busy/done"}, {busy, done}, 2'b10);
      q1.push_back(0); q2.push_back(0);
      step();
      pop_check({t, " drain"});
    end
    check({t, " done"}, {busy, done}, 2'b11);
    check({t, " count"}, vec_count, j.exp_count);
    step();
    check({t, " idle busy/done"}, {busy, done}, 2'b00);
    check({t, " count held"}, vec_count, j.exp_count);
    check({t, " psum"}, {psum_in1, psum_in2}, 0);
  endtask

  initial begin
    jobs[0] = '{w11:1, w12:2, w21:3, w22:4, nvec:2, a0:{8'd0, 8'd0, 8'd2, 8'd1},
                a1:{8'd0, 8'd0, 8'd4, 8'd3}, pattern:8'hFF, start_mid:0, exp_count:2};
    jobs[1] = '{w11:1, w12:2, w21:3, w22:4, nvec:2, a0:{8'd0, 8'd0, 8'd2, 8'd1},
                a1:{8'd0, 8'd0, 8'd4, 8'd3}, pattern:8'b1111_1101, start_mid:0, exp_count:2};
    jobs[2] = '{w11:9, w12:8, w21:7, w22:6, nvec:1, a0:{8'd0, 8'd0, 8'd0, 8'd5},
                a1:{8'd0, 8'd0, 8'd0, 8'd7}, pattern:8'hFF, start_mid:0, exp_count:1};
    jobs[3] = '{w11:10, w12:20, w21:30, w22:40, nvec:3, a0:{8'd0, 8'd30, 8'd20, 8'd10},
                a1:{8'd0, 8'd31, 8'd21, 8'd11}, pattern:8'hFF, start_mid:1, exp_count:3};
    jobs[4] = '{w11:255, w12:128, w21:1, w22:0, nvec:4, a0:{8'd4, 8'd3, 8'd2, 8'd1},
                a1:{8'd40, 8'd30, 8'd20, 8'd10}, pattern:8'b1001_0110, start_mid:0, exp_count:4};

    rst = 1; idle_inputs(); w11 = 0; w12 = 0; w21 = 0; w22 = 0;
    #3;
    check("reset outputs", {act_ready, clear, weight_load, busy, done, w_in1, w_in2,
                            act_in1, act_in2, vec_count}, 0);
    step(); step();
    rst = 0;
    step();
    check("idle busy", busy, 0);

    for (int i = 0; i < 5; i++) run_job(jobs[i], i);

    // reset while in WLOAD1, then a fresh job must complete
    w11 = 1; w12 = 2; w21 = 3; w22 = 4; start = 1;
    step(); start = 0;
    step(); step();
    check("pre-reset wl1", weight_load, 1);
    #2 rst = 1;
    #1;
    check("async reset wl/busy", {weight_load, busy, clear, done}, 0);
    check("async reset w_in", {w_in1, w_in2}, 0);
    step();
    check("held reset", {busy, done, act_ready}, 0);
    rst = 0;
    run_job(jobs[2], 5);

    // saturation: 300 back-to-back vectors
    start = 1; step(); start = 0;
    step(); step(); step();
    for (int k = 0; k < 300; k++) begin
      act_valid = 1; act_a0 = k[7:0]; act_a1 = ~k[7:0]; act_last = (k == 299);
      step();
      if (k == 0)   check("sat count1", vec_count, 1);
      if (k == 10)  check("sat act_in1", act_in1, 10);
      if (k == 11)  check("sat act_in2", act_in2, 8'hF5);
      if (k == 254) check("sat count255", vec_count, 255);
      if (k == 255) check("sat hold", vec_count, 255);
    end
    idle_inputs();
    check("sat flush ready", act_ready, 0);
    check("sat final count", vec_count, 255);
    for (int d = 0; d <= DRAIN; d++) step();
    check("sat done", done, 1);
    step();
    check("sat idle", {busy, done, vec_count}, {2'b00, 8'd255});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
